inst_loader: RTL and testbench

- Program loader for the instruction memory: the write side of the instruction store, where the fetch path is the read side.
- Accepts a byte stream from the host/testbench over a valid/ready handshake and parses a framed image: length header, instruction payload, XOR checksum.
- Issues one write per instruction into the instruction RAM.
- Holds the CPU in reset-like hold while loading; reports done or error.

---
 rtl/inst_loader_pkg.sv | 30 +++
 rtl/inst_loader_if.sv | 23 ++
 rtl/xor_accum.sv | 31 +++
 rtl/inst_loader.sv | 169 ++++++++++++++++
 tb/tb_inst_loader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding plus a helper that marks HI-byte bits that must be zero for a given word width.
package inst_pkg;

   localparam int LOADER_A         = 10;
   localparam int LOADER_W         = 9;
   localparam int LOADER_MAX_WORDS = 1 << LOADER_A;
   localparam int BYTES_PER_INST   = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_INST_LO,
      S_INST_HI,
      S_CHK,
      S_DONE,
      S_ERR
   } loader_state_t;

   // Bits of the HI byte above inst[W-1:8]; they must arrive as zero.
   function automatic logic [7:0] hi_rsvd_mask(input int w);
      logic [7:0] m;
      for (int i = 0; i < 8; i++) begin
         m[i] = (i > w - 9);
      end
      return m;
   endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
// master = host/bench side, slave = loader side.
interface inst_loader_if #(
   parameter int A = 10,
   parameter int W = 9
) ();
   logic [7:0]   InData;
   logic         InValid;
   logic         InReady;
   logic         WrEn;
   logic [A-1:0] WrAddr;
   logic [W-1:0] WrData;

   modport master (
      output InData, InValid,
      input  InReady, WrEn, WrAddr, WrData
   );

   modport slave (
      input  InData, InValid,
      output InReady, WrEn, WrAddr, WrData
   );
endinterface

// File: rtl/xor_accum.sv
// 8-bit running XOR with synchronous clear and enable; result visible the cycle after enable.
// No flow control: the caller only enables it on accepted bytes.
module xor_accum (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);
   logic [7:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = 8'h00;
      end else if (en) begin
         acc_d = acc_q ^ din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= 8'h00;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;
endmodule

// File: rtl/inst_loader.sv
// Parses a framed byte image (LEN, word pairs, XOR) and writes each word to instruction RAM one cycle after its HI byte.
// InReady is high in every receive state; InValid low simply stalls the parser.
module inst_loader
   import inst_pkg::*;
#(
   parameter int A = LOADER_A,
   parameter int W = LOADER_W
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Start,
   inst_loader_if.slave  bus,
   output logic          CpuHold,
   output logic          Done,
   output logic          Error,
   output logic [A:0]    WordCount
);
   localparam logic [16:0] MAX_WORDS_17 = 17'(1 << A);
   localparam logic [7:0]  RSVD_MASK    = hi_rsvd_mask(W);
   localparam logic [A:0]  CNT_ONE      = 1;

   loader_state_t state_q, state_d;
   logic [7:0]    len_lo_q, len_lo_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    lo_q, lo_d;
   logic          in_ready_q, in_ready_d;
   logic          wr_en_q, wr_en_d;
   logic [A-1:0]  wr_addr_q, wr_addr_d;
   logic [W-1:0]  wr_data_q, wr_data_d;
   logic          cpu_hold_q, cpu_hold_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [A:0]    word_count_q, word_count_d;

   logic          chk_clr, chk_en;
   logic [7:0]    chk_acc;
   logic          xfer;
   logic          busy_d;
   logic [16:0]   len_in_17;
   logic [16:0]   cnt_next_17;

   assign xfer        = bus.InValid & in_ready_q;
   assign len_in_17   = {1'b0, bus.InData, len_lo_q};
   assign cnt_next_17 = {{(16 - A){1'b0}}, word_count_q} + 17'd1;

   xor_accum u_chk (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clr   (chk_clr),
      .en    (chk_en),
      .din   (bus.InData),
      .acc   (chk_acc)
   );

   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      lo_d         = lo_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      chk_clr      = 1'b0;
      chk_en       = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (Start) begin
               state_d      = S_LEN_LO;
               word_count_d = '0;
               chk_clr      = 1'b1;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_lo_d = bus.InData;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d = len_in_17[15:0];
               if (len_in_17 > MAX_WORDS_17) begin
                  state_d = S_ERR;
               end else if (len_in_17 == 17'd0) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_INST_LO;
               end
            end
         end
         S_INST_LO: begin
            if (xfer) begin
               lo_d    = bus.InData;
               chk_en  = 1'b1;
               state_d = S_INST_HI;
            end
         end
         S_INST_HI: begin
            if (xfer) begin
               chk_en = 1'b1;
               if ((bus.InData & RSVD_MASK) != 8'h00) begin
                  state_d = S_ERR;
               end else begin
                  wr_en_d      = 1'b1;
                  wr_addr_d    = word_count_q[A-1:0];
                  wr_data_d    = {bus.InData[W-9:0], lo_q};
                  word_count_d = word_count_q + CNT_ONE;
                  state_d      = (cnt_next_17 < {1'b0, len_q}) ? S_INST_LO : S_CHK;
               end
            end
         end
         S_CHK: begin
            if (xfer) begin
               state_d = (bus.InData == chk_acc) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered images of the next state.
      busy_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_INST_LO) ||
                   (state_d == S_INST_HI) || (state_d == S_CHK);
      in_ready_d = busy_d;
      cpu_hold_d = busy_d;
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERR);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         len_lo_q     <= 8'h00;
         len_q        <= 16'h0000;
         lo_q         <= 8'h00;
         in_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         lo_q         <= lo_d;
         in_ready_q   <= in_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         error_q      <= error_d;
         word_count_q <= word_count_d;
      end
   end

   assign bus.InReady = in_ready_q;
   assign bus.WrEn    = wr_en_q;
   assign bus.WrAddr  = wr_addr_q;
   assign bus.WrData  = wr_data_q;
   assign CpuHold     = cpu_hold_q;
   assign Done        = done_q;
   assign Error       = error_q;
   assign WordCount   = word_count_q;
endmodule

// File: tb/tb_inst_loader.sv
// Directed frames into inst_loader; expected RAM writes go into a queue that a negedge monitor drains.
module tb_inst_loader;
   import inst_pkg::*;

   localparam int A = LOADER_A;
   localparam int W = LOADER_W;

   typedef struct packed {
      logic [A-1:0] addr;
      logic [W-1:0] data;
   } wr_t;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Start;
   logic       CpuHold;
   logic       Done;
   logic       Error;
   logic [A:0] WordCount;

   inst_loader_if #(.A(A), .W(W)) bus ();

   inst_loader #(.A(A), .W(W)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .bus       (bus.slave),
      .CpuHold   (CpuHold),
      .Done      (Done),
      .Error     (Error),
      .WordCount (WordCount)
   );

   always #5 Clk = ~Clk;

   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] frame[$];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expected write.
   initial begin
      forever begin
         @(negedge Clk);
         if (bus.WrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_write: addr %0h data %0h with no write expected",
                        bus.WrAddr, bus.WrData);
            end else begin
               mon_e = exp_q.pop_front();
               cmp("wr_addr", 32'(bus.WrAddr), 32'(mon_e.addr));
               cmp("wr_data", 32'(bus.WrData), 32'(mon_e.data));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      int   k;
      for (int g = 0; g < gap; g++) begin
         bus.InValid = 1'b0;
         @(negedge Clk);
         cmp("gap_in_ready", 32'(bus.InReady), 32'd1);
         cmp("gap_cpu_hold", 32'(CpuHold), 32'd1);
         tick();
      end
      bus.InData  = b;
      bus.InValid = 1'b1;
      r = 1'b0;
      k = 0;
      while (!r && k < 20) begin
         @(negedge Clk);
         r = bus.InReady;
         tick();
         k++;
      end
      if (!r) begin
         n_cmp++;
         n_err++;
         $display("FAIL byte_accept_timeout: byte %0h never accepted", b);
      end
      bus.InValid = 1'b0;
   endtask

   task automatic run_frame(input int maxgap);
      foreach (frame[i]) begin
         send_byte(frame[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
      end
   endtask

   task automatic check_result(input string name, input logic exp_done, input logic exp_err,
                               input int exp_wc);
      int k;
      k = 0;
      while (k < 50) begin
         @(negedge Clk);
         if (Done === 1'b1 || Error === 1'b1) break;
         k++;
      end
      if (k == 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: Done=%0b Error=%0b never set", name, Done, Error);
      end
      cmp({name, "_done"}, 32'(Done), 32'(exp_done));
      cmp({name, "_error"}, 32'(Error), 32'(exp_err));
      cmp({name, "_wordcount"}, 32'(WordCount), 32'(exp_wc));
      cmp({name, "_cpu_hold"}, 32'(CpuHold), 32'd0);
      cmp({name, "_in_ready"}, 32'(bus.InReady), 32'd0);
      cmp({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   task automatic check_reset_vals(input string name);
      @(negedge Clk);
      cmp({name, "_in_ready"}, 32'(bus.InReady), 32'd0);
      cmp({name, "_wr_en"}, 32'(bus.WrEn), 32'd0);
      cmp({name, "_wr_addr"}, 32'(bus.WrAddr), 32'd0);
      cmp({name, "_wr_data"}, 32'(bus.WrData), 32'd0);
      cmp({name, "_cpu_hold"}, 32'(CpuHold), 32'd0);
      cmp({name, "_done"}, 32'(Done), 32'd0);
      cmp({name, "_error"}, 32'(Error), 32'd0);
      cmp({name, "_wordcount"}, 32'(WordCount), 32'd0);
      tick();
   endtask

   task automatic push_good_writes();
      exp_q.push_back('{addr: 10'd0, data: 9'h134});
      exp_q.push_back('{addr: 10'd1, data: 9'h07F});
   endtask

   initial begin
      Reset_n     = 1'b0;
      Start       = 1'b0;
      bus.InData  = 8'h00;
      bus.InValid = 1'b0;
      repeat (3) tick();
      check_reset_vals("reset");
      Reset_n = 1'b1;
      tick();

      // Good load: checksum 34^01^7F^00 = 4A
      push_good_writes();
      pulse_start();
      frame = '{8'h02, 8'h00, 8'h34, 8'h01, 8'h7F, 8'h00, 8'h4A};
      run_frame(0);
      check_result("good", 1'b1, 1'b0, 2);

      // Empty image
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00};
      run_frame(0);
      check_result("empty", 1'b1, 1'b0, 0);

      // Bad checksum: expected FF^01 = FE, sent 00
      exp_q.push_back('{addr: 10'd0, data: 9'h1FF});
      pulse_start();
      frame = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'h00};
      run_frame(0);
      check_result("badchk", 1'b0, 1'b1, 1);

      // Reserved HI bit set (02 has bit 1 set, W=9 allows only bit 0)
      pulse_start();
      frame = '{8'h01, 8'h00, 8'h12, 8'h02};
      run_frame(0);
      check_result("rsvd", 1'b0, 1'b1, 0);

      // Oversize header N = 1025
      pulse_start();
      frame = '{8'h01, 8'h04};
      run_frame(0);
      check_result("oversize", 1'b0, 1'b1, 0);

      // Exactly 2**A words is legal in the header: send only the header and first pair, then reset
      // is not needed; instead confirm N=1024 does not error immediately.
      pulse_start();
      frame = '{8'h00, 8'h04};
      run_frame(0);
      @(negedge Clk);
      cmp("maxlen_no_error", 32'(Error), 32'd0);
      cmp("maxlen_in_ready", 32'(bus.InReady), 32'd1);
      tick();
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      tick();

      // Stalled good load
      push_good_writes();
      pulse_start();
      frame = '{8'h02, 8'h00, 8'h34, 8'h01, 8'h7F, 8'h00, 8'h4A};
      run_frame(5);
      check_result("stall", 1'b1, 1'b0, 2);

      // Start during INST_LO must be ignored; the rest of the frame still completes
      push_good_writes();
      pulse_start();
      frame = '{8'h02, 8'h00};
      run_frame(0);
      pulse_start();
      @(negedge Clk);
      cmp("busy_start_hold", 32'(CpuHold), 32'd1);
      cmp("busy_start_ready", 32'(bus.InReady), 32'd1);
      tick();
      frame = '{8'h34, 8'h01, 8'h7F, 8'h00, 8'h4A};
      run_frame(0);
      check_result("busy_start", 1'b1, 1'b0, 2);

      // Reset while in INST_HI
      pulse_start();
      frame = '{8'h02, 8'h00, 8'h34};
      run_frame(0);
      Reset_n = 1'b0;
      check_reset_vals("midreset");
      Reset_n = 1'b1;
      tick();

      push_good_writes();
      pulse_start();
      frame = '{8'h02, 8'h00, 8'h34, 8'h01, 8'h7F, 8'h00, 8'h4A};
      run_frame(0);
      check_result("after_reset", 1'b1, 1'b0, 2);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
